mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have: clk_i  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: MemRead_MEM / MemWrite_MEM  in  1 each  data-access request from the MEM stage.
REQ-004 SHALL have: FUResult_MEM  in  16  data address; rtdata_MEM  in  16  store data.
REQ-005 SHALL have: if_req_i  in  1  fetch request; if_addr_i  in  16  fetch address.
REQ-006 SHALL have: mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  16; mem_wdata_o  out  16; all go to the single shared memory.
REQ-007 SHALL have: mem_ack_i  in  1  memory completion; mem_rdata_i  in  16  read data, valid with mem_ack_i.
REQ-008 SHALL have: dmem_rdata_o  out  16; stall_mem_o  out  1  freezes the pipeline registers up to and including EX/MEM.
REQ-009 SHALL have: if_rdata_o  out  16; if_valid_o  out  1; if_stall_o  out  1; err_o  out  1.

Function
REQ-010 SHALL implement the states IDLE, D_BUSY, D_DONE and F_BUSY.
REQ-011 IDLE SHALL define dreq = MemRead_MEM|MemWrite_MEM; in IDLE only dreq -> D_BUSY; only if_req_i -> F_BUSY; neither -> IDLE.
REQ-012 IDLE with both requests SHALL grant the requester not granted last; the last_grant flag SHALL reset to "fetch", so data wins the first tie.
REQ-013 On a grant, mem_addr_o, mem_we_o and mem_wdata_o SHALL be registered and held constant until the matching ack.
REQ-014 mem_we_o SHALL equal MemWrite_MEM at the grant; if MemRead_MEM and MemWrite_MEM are both 1, the write SHALL win.
REQ-015 mem_req_o SHALL be 1 exactly while the state is D_BUSY or F_BUSY.
REQ-016 In D_BUSY, mem_ack_i=1 SHALL load mem_rdata_i into dmem_rdata_o (loads only) and move the state to D_DONE.
REQ-017 D_DONE SHALL last exactly one cycle and then return to IDLE.
REQ-018 dmem_rdata_o SHALL hold its value until the next data load completes.
REQ-019 stall_mem_o SHALL be combinational: dreq AND state != D_DONE.
REQ-020 Minimum data-access latency SHALL be 3 cycles (grant, ack, done).
REQ-021 In F_BUSY, mem_ack_i=1 SHALL register mem_rdata_i into if_rdata_o, pulse if_valid_o for exactly one cycle on the next cycle, and return the state to IDLE.
REQ-022 if_stall_o SHALL equal if_req_i AND NOT if_valid_o.
REQ-023 mem_ack_i SHALL be ignored in IDLE and D_DONE.
REQ-024 A fetch SHALL never pre-empt a granted data access, and a data access SHALL never pre-empt a granted fetch.
REQ-025 Request inputs that drop while the state is BUSY SHALL NOT abort the transaction.

Reset
REQ-026 With rst_n=0, the state SHALL go immediately to IDLE, without waiting for a clock edge.
REQ-027 With rst_n=0, mem_req_o, mem_we_o, if_valid_o and err_o SHALL be 0.
REQ-028 With rst_n=0, mem_addr_o, mem_wdata_o, dmem_rdata_o and if_rdata_o SHALL be 16'h0000, and last_grant SHALL be "fetch".
REQ-029 A reset during BUSY SHALL abandon the transaction; an ack arriving after reset SHALL be ignored.

Configuration
REQ-030 With ARB_TIMEOUT_EN defined, a 4-bit counter SHALL clear on each grant and increment each BUSY cycle without ack.
REQ-031 With ARB_TIMEOUT_EN defined, the 15th BUSY cycle without ack SHALL complete the access as if acked with rdata 16'h0000 and set err_o, which stays set until reset.
REQ-032 Without ARB_TIMEOUT_EN, BUSY SHALL wait indefinitely and err_o SHALL be tied to 0.

Verification
REQ-033 Load: MemRead_MEM=1, addr 16'h0040, ack after 2 cycles with 16'h1234 -> mem_we_o=0, stall_mem_o high for 3 cycles, dmem_rdata_o=16'h1234 in D_DONE.
REQ-034 Store: MemWrite_MEM=1, addr 16'h0010, rtdata_MEM=16'hBEEF, ack immediately -> mem_we_o=1, mem_wdata_o=16'hBEEF, dmem_rdata_o unchanged.
REQ-035 Tie: dreq and if_req_i both set continuously out of reset -> grants alternate data, fetch, data.
REQ-036 Fetch: if_req_i=1, addr 16'h0002, ack 16'h5A5A -> if_valid_o pulses once, if_rdata_o=16'h5A5A, if_stall_o drops in the same cycle.
REQ-037 Reset: rst_n dropped mid D_BUSY, then a late ack -> mem_req_o=0 immediately, state IDLE, outputs at reset values, ack ignored.
REQ-038 Timeout with ARB_TIMEOUT_EN: no ack -> 15th BUSY cycle completes with rdata 16'h0000 and err_o=1; without the macro, mem_req_o stays 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between the MEM-stage data access and the
// instruction fetch. Both requesters compete only in IDLE. A tie goes to the
// requester that was not granted last, which makes back-to-back ties
// alternate. Once a grant is made, the address, write enable and write data
// are registered and held until the memory acks. Neither side can pre-empt
// the other, and a request that drops mid-transaction does not abort it.
//
// States: IDLE -> D_BUSY -> D_DONE -> IDLE   (data access)
//         IDLE -> F_BUSY -> IDLE             (fetch)
//
// Optional feature (macro ARB_TIMEOUT_EN): a BUSY state that sees no ack for
// 15 cycles completes as if acked with read data 16'h0000 and sets err_o.
// err_o stays set until reset. Without the macro, BUSY waits forever and
// err_o is tied to 0.
//
// Ports
//   clk_i         in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   MemRead_MEM   in   data load request from MEM stage
//   MemWrite_MEM  in   data store request from MEM stage (wins over read)
//   FUResult_MEM  in   16-bit data address
//   rtdata_MEM    in   16-bit store data
//   if_req_i      in   fetch request
//   if_addr_i     in   16-bit fetch address
//   mem_req_o     out  memory request, high while D_BUSY or F_BUSY
//   mem_we_o      out  memory write enable (registered at grant)
//   mem_addr_o    out  memory address (registered at grant)
//   mem_wdata_o   out  memory write data (registered at grant)
//   mem_ack_i     in   memory completion
//   mem_rdata_i   in   memory read data, valid with mem_ack_i
//   dmem_rdata_o  out  last completed load data
//   stall_mem_o   out  freezes pipeline registers up to EX/MEM
//   if_rdata_o    out  last completed fetch data
//   if_valid_o    out  one-cycle pulse after a fetch completes
//   if_stall_o    out  fetch stall
//   err_o         out  sticky timeout error
// ---------------------------------------------------------------------------
module mem_port_arbiter (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [15:0] FUResult_MEM,
    input  logic [15:0] rtdata_MEM,
    input  logic        if_req_i,
    input  logic [15:0] if_addr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_rdata_i,
    output logic [15:0] dmem_rdata_o,
    output logic        stall_mem_o,
    output logic [15:0] if_rdata_o,
    output logic        if_valid_o,
    output logic        if_stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDBusy = 2'd1,
        StDDone = 2'd2,
        StFBusy = 2'd3
    } state_e;

    state_e      state;
    logic        last_grant_data;  // 0 = fetch granted last (reset value)
    logic        dreq;
    logic        grant_data;
    logic        grant_fetch;
    logic        ack_eff;          // real ack, or forced completion on timeout
    logic [15:0] rdata_eff;

    assign dreq = MemRead_MEM | MemWrite_MEM;

    // On a tie, grant the side that did not win last time.
    assign grant_data  = dreq & (~if_req_i | ~last_grant_data);
    assign grant_fetch = if_req_i & (~dreq | last_grant_data);

`ifdef ARB_TIMEOUT_EN
    logic [3:0] tmo_cnt;
    logic       tmo_hit;
    logic       err_q;

    // tmo_cnt counts the earlier ack-less BUSY cycles, so a value of 14
    // marks the 15th cycle without an ack.
    assign tmo_hit   = ~mem_ack_i & (tmo_cnt == 4'd14);
    assign ack_eff   = mem_ack_i | tmo_hit;
    assign rdata_eff = mem_ack_i ? mem_rdata_i : 16'h0000;
    assign err_o     = err_q;
`else
    assign ack_eff   = mem_ack_i;
    assign rdata_eff = mem_rdata_i;
    assign err_o     = 1'b0;
`endif

    assign mem_req_o   = (state == StDBusy) | (state == StFBusy);
    assign stall_mem_o = dreq & (state != StDDone);
    assign if_stall_o  = if_req_i & ~if_valid_o;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state           <= StIdle;
            last_grant_data <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= 16'h0000;
            mem_wdata_o     <= 16'h0000;
            dmem_rdata_o    <= 16'h0000;
            if_rdata_o      <= 16'h0000;
            if_valid_o      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt         <= 4'd0;
            err_q           <= 1'b0;
`endif
        end else begin
            if_valid_o <= 1'b0;
            case (state)
                StIdle: begin
                    // mem_ack_i is deliberately ignored here.
                    if (grant_data) begin
                        state           <= StDBusy;
                        last_grant_data <= 1'b1;
                        mem_addr_o      <= FUResult_MEM;
                        mem_we_o        <= MemWrite_MEM;
                        mem_wdata_o     <= rtdata_MEM;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt         <= 4'd0;
`endif
                    end else if (grant_fetch) begin
                        state           <= StFBusy;
                        last_grant_data <= 1'b0;
                        mem_addr_o      <= if_addr_i;
                        mem_we_o        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt         <= 4'd0;
`endif
                    end
                end
                StDBusy: begin
                    if (ack_eff) begin
                        if (!mem_we_o) begin
                            dmem_rdata_o <= rdata_eff;
                        end
                        state <= StDDone;
                    end
`ifdef ARB_TIMEOUT_EN
                    if (tmo_hit) begin
                        err_q <= 1'b1;
                    end else if (!mem_ack_i) begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
`endif
                end
                StDDone: begin
                    // One cycle with stall released so the pipeline advances.
                    state <= StIdle;
                end
                StFBusy: begin
                    if (ack_eff) begin
                        if_rdata_o <= rdata_eff;
                        if_valid_o <= 1'b1;
                        state      <= StIdle;
                    end
`ifdef ARB_TIMEOUT_EN
                    if (tmo_hit) begin
                        err_q <= 1'b1;
                    end else if (!mem_ack_i) begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        MemRead_MEM, MemWrite_MEM;
    logic [15:0] FUResult_MEM, rtdata_MEM;
    logic        if_req_i;
    logic [15:0] if_addr_i;
    logic        mem_req_o, mem_we_o;
    logic [15:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [15:0] mem_rdata_i;
    logic [15:0] dmem_rdata_o;
    logic        stall_mem_o;
    logic [15:0] if_rdata_o;
    logic        if_valid_o, if_stall_o, err_o;

    mem_port_arbiter dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .MemRead_MEM  (MemRead_MEM),
        .MemWrite_MEM (MemWrite_MEM),
        .FUResult_MEM (FUResult_MEM),
        .rtdata_MEM   (rtdata_MEM),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .dmem_rdata_o (dmem_rdata_o),
        .stall_mem_o  (stall_mem_o),
        .if_rdata_o   (if_rdata_o),
        .if_valid_o   (if_valid_o),
        .if_stall_o   (if_stall_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference model
    logic        m_last_data;  // last grant went to data
    logic [15:0] m_dmem;       // expected dmem_rdata_o
    logic [15:0] m_if;         // expected if_rdata_o
    int          stall_cnt;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        MemRead_MEM  = 1'b0;
        MemWrite_MEM = 1'b0;
        if_req_i     = 1'b0;
        mem_ack_i    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk1({tag, "_req"}, mem_req_o, 1'b0);
        chk1({tag, "_we"}, mem_we_o, 1'b0);
        chk1({tag, "_valid"}, if_valid_o, 1'b0);
        chk1({tag, "_err"}, err_o, 1'b0);
        chk16({tag, "_addr"}, mem_addr_o, 16'h0000);
        chk16({tag, "_wdata"}, mem_wdata_o, 16'h0000);
        chk16({tag, "_dmem"}, dmem_rdata_o, 16'h0000);
        chk16({tag, "_ifdata"}, if_rdata_o, 16'h0000);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_reset_values("rst");
        @(negedge clk_i);
        rst_n       = 1'b1;
        m_last_data = 1'b0;
        m_dmem      = 16'h0000;
        m_if        = 16'h0000;
    endtask

    // One complete transaction starting from IDLE at a falling edge.
    task automatic do_txn(input logic rd, input logic wr, input logic ifr,
                          input logic [15:0] daddr, input logic [15:0] wdat,
                          input logic [15:0] faddr, input logic [15:0] rdat,
                          input int delay, input logic drop);
        logic        dreq;
        logic        is_data;
        logic        exp_we;
        logic [15:0] exp_addr;
        dreq        = rd | wr;
        is_data     = dreq && (!ifr || !m_last_data);
        m_last_data = is_data;
        exp_addr    = is_data ? daddr : faddr;
        exp_we      = is_data & wr;
        stall_cnt   = 0;

        MemRead_MEM  = rd;
        MemWrite_MEM = wr;
        FUResult_MEM = daddr;
        rtdata_MEM   = wdat;
        if_req_i     = ifr;
        if_addr_i    = faddr;
        mem_ack_i    = 1'($urandom_range(0, 1));  // must be ignored in IDLE
        mem_rdata_i  = 16'($urandom);
        #1;
        chk1("idle_stall", stall_mem_o, dreq);
        chk1("idle_if_stall", if_stall_o, ifr);
        chk1("idle_req", mem_req_o, 1'b0);
        stall_cnt += int'(stall_mem_o);

        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk1("grant_req", mem_req_o, 1'b1);
        chk16("grant_addr", mem_addr_o, exp_addr);
        chk1("grant_we", mem_we_o, exp_we);
        if (exp_we) chk16("grant_wdata", mem_wdata_o, wdat);
        chk1("grant_stall", stall_mem_o, dreq);
        stall_cnt += int'(stall_mem_o);
        if (drop) begin
            MemRead_MEM  = 1'b0;
            MemWrite_MEM = 1'b0;
            if_req_i     = 1'b0;
            FUResult_MEM = 16'($urandom);
            if_addr_i    = 16'($urandom);
            rtdata_MEM   = 16'($urandom);
        end

        for (int k = 0; k < delay; k++) begin
            mem_rdata_i = 16'($urandom);
            @(negedge clk_i);
            chk1("busy_req", mem_req_o, 1'b1);
            chk16("busy_addr", mem_addr_o, exp_addr);
            chk1("busy_we", mem_we_o, exp_we);
            chk1("busy_stall", stall_mem_o, drop ? 1'b0 : dreq);
            chk1("busy_if_stall", if_stall_o, drop ? 1'b0 : ifr);
            stall_cnt += int'(stall_mem_o);
        end

        mem_ack_i   = 1'b1;
        mem_rdata_i = rdat;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk1("after_req", mem_req_o, 1'b0);
        if (is_data) begin
            if (!wr) m_dmem = rdat;
            chk1("done_stall", stall_mem_o, 1'b0);
            chk16("done_dmem", dmem_rdata_o, m_dmem);
            chk1("done_valid", if_valid_o, 1'b0);
        end else begin
            m_if = rdat;
            chk1("fetch_valid", if_valid_o, 1'b1);
            chk16("fetch_rdata", if_rdata_o, m_if);
            chk1("fetch_if_stall", if_stall_o, 1'b0);
        end
        stall_cnt += int'(stall_mem_o);

        // Ack in D_DONE / IDLE must be ignored.
        idle_inputs();
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = 16'($urandom);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk1("post_valid", if_valid_o, 1'b0);
        chk1("post_req", mem_req_o, 1'b0);
        chk16("post_dmem", dmem_rdata_o, m_dmem);
        chk16("post_ifdata", if_rdata_o, m_if);
    endtask

    initial begin
        logic rd, wr, ifr;
        rst_n        = 1'b0;
        idle_inputs();
        FUResult_MEM = 16'h0000;
        rtdata_MEM   = 16'h0000;
        if_addr_i    = 16'h0000;
        mem_rdata_i  = 16'h0000;
        #2;
        check_reset_values("init");
        do_reset();

        // Load: ack on the second BUSY cycle
        do_txn(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 16'h1234, 1, 1'b0);
        chk16("load_stall_cycles", 16'(stall_cnt), 16'd3);
        chk16("load_data", dmem_rdata_o, 16'h1234);

        // Store: immediate ack, load data must be kept
        do_txn(1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 16'hDEAD, 0, 1'b0);
        chk16("store_dmem_kept", dmem_rdata_o, 16'h1234);

        // Fetch
        do_txn(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0002, 16'h5A5A, 0, 1'b0);
        chk16("fetch_data", if_rdata_o, 16'h5A5A);

        // Tie held continuously out of reset: data, fetch, data
        do_reset();
        MemRead_MEM  = 1'b1;
        FUResult_MEM = 16'h0100;
        if_req_i     = 1'b1;
        if_addr_i    = 16'h0200;
        @(negedge clk_i);
        chk16("tie1_addr", mem_addr_o, 16'h0100);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'h1111;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk1("tie_gap_req", mem_req_o, 1'b0);
        @(negedge clk_i);
        chk16("tie2_addr", mem_addr_o, 16'h0200);
        chk1("tie2_we", mem_we_o, 1'b0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'h2222;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk1("tie2_valid", if_valid_o, 1'b1);
        @(negedge clk_i);
        chk1("tie3_req", mem_req_o, 1'b1);
        chk16("tie3_addr", mem_addr_o, 16'h0100);
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        @(negedge clk_i);

        // Reset in the middle of D_BUSY, then a late ack
        do_reset();
        MemRead_MEM  = 1'b1;
        FUResult_MEM = 16'h0080;
        @(negedge clk_i);
        chk1("rstbusy_req_before", mem_req_o, 1'b1);
        rst_n       = 1'b0;
        MemRead_MEM = 1'b0;
        #1;
        check_reset_values("rstbusy");
        @(negedge clk_i);
        rst_n       = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'hFFFF;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk1("late_ack_req", mem_req_o, 1'b0);
        chk16("late_ack_dmem", dmem_rdata_o, 16'h0000);
        chk1("late_ack_stall", stall_mem_o, 1'b0);
        m_last_data = 1'b0;
        m_dmem      = 16'h0000;
        m_if        = 16'h0000;

        // No ack at all
        MemRead_MEM  = 1'b1;
        FUResult_MEM = 16'h0300;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            @(negedge clk_i);
            chk1("tmo_busy_req", mem_req_o, 1'b1);
            chk1("tmo_busy_err", err_o, 1'b0);
        end
        @(negedge clk_i);
        chk1("tmo_done_req", mem_req_o, 1'b0);
        chk1("tmo_done_err", err_o, 1'b1);
        chk16("tmo_done_dmem", dmem_rdata_o, 16'h0000);
        chk1("tmo_done_stall", stall_mem_o, 1'b0);
        MemRead_MEM = 1'b0;
        repeat (3) @(negedge clk_i);
        chk1("tmo_err_sticky", err_o, 1'b1);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            chk1("wait_busy_req", mem_req_o, 1'b1);
            chk1("wait_busy_err", err_o, 1'b0);
        end
        MemRead_MEM = 1'b0;
`endif
        do_reset();

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            rd  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            ifr = 1'($urandom_range(0, 1));
            if (!(rd | wr | ifr)) ifr = 1'b1;
            do_txn(rd, wr, ifr, 16'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
